// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: funct3 codes, instruction IDs, size and state encodings.
// The ISSUE2 state exists only when STORE_MISALIGNED_SPLIT_EN is defined.
package store_unit_pkg;

  localparam int FUNCT3_W    = 3;
  localparam int INST_ID_LEN = 3;

  localparam logic [FUNCT3_W-1:0] SB_FUN3 = 3'b000;
  localparam logic [FUNCT3_W-1:0] SH_FUN3 = 3'b001;
  localparam logic [FUNCT3_W-1:0] SW_FUN3 = 3'b010;
  localparam logic [FUNCT3_W-1:0] SD_FUN3 = 3'b011;

  localparam logic [INST_ID_LEN-1:0] NONE_ID = 3'd0;
  localparam logic [INST_ID_LEN-1:0] SB_ID   = 3'd1;
  localparam logic [INST_ID_LEN-1:0] SH_ID   = 3'd2;
  localparam logic [INST_ID_LEN-1:0] SW_ID   = 3'd3;
  localparam logic [INST_ID_LEN-1:0] SD_ID   = 3'd4;

  // log2 of the access size in bytes
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef STORE_MISALIGNED_SPLIT_EN
    ST_ISSUE2 = 2'd2,
`endif
    ST_ISSUE  = 2'd1
  } state_e;

  typedef struct packed {
    logic                   legal;
    logic [INST_ID_LEN-1:0] id;
    size_e                  size;
  } dec_t;

  function automatic dec_t decode_store(input logic [FUNCT3_W-1:0] f3, input logic has_sd);
    dec_t d;
    d.legal = 1'b1;
    d.id    = NONE_ID;
    d.size  = SZ_B;
    case (f3)
      SB_FUN3: begin d.id = SB_ID; d.size = SZ_B; end
      SH_FUN3: begin d.id = SH_ID; d.size = SZ_H; end
      SW_FUN3: begin d.id = SW_ID; d.size = SZ_W; end
      SD_FUN3: begin
        if (has_sd) begin
          d.id   = SD_ID;
          d.size = SZ_D;
        end else begin
          d.legal = 1'b0;
        end
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] size_mask(input size_e s);
    case (s)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      SZ_D:    return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input size_e s);
    case (s)
      SZ_B:    return 3'd0;
      SZ_H:    return 3'd1;
      SZ_W:    return 3'd3;
      SZ_D:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input size_e s);
    case (s)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Byte-strobe and lane-shifted write-data generator, shared by both beats of a store.
module store_lane_gen
  import store_unit_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  size_e             size,
  input  logic [OFF_W-1:0]  off,
  input  logic [XLEN-1:0]   data,
  input  logic              beat2,
  output logic [NB-1:0]     wstrb,
  output logic [XLEN-1:0]   wdata
);

  logic [2*NB-1:0]   base_s;
  logic [2*NB-1:0]   mask_s;
  logic [2*XLEN-1:0] wide_s;

  // Shift over a double-width word: the low half is beat 1, the spill-over high half is beat 2.
  always_comb begin
    base_s      = '0;
    base_s[7:0] = size_mask(size);
    mask_s      = base_s << off;
    wide_s      = {{XLEN{1'b0}}, data} << {off, 3'b000};
    if (beat2) begin
      wstrb = mask_s[2*NB-1:NB];
      wdata = wide_s[2*XLEN-1:XLEN];
    end else begin
      wstrb = mask_s[NB-1:0];
      wdata = wide_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store path: funct3 decode, lane/strobe generation and a req/gnt data-memory write handshake.
// Optional macro STORE_MISALIGNED_SPLIT_EN splits word-crossing stores into two beats instead of trapping.
module store_unit
  import store_unit_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int ADDR_W = 32,
  localparam int NB     = XLEN / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FUNCT3_W-1:0]    in_funct3,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [XLEN-1:0]        in_data,
  output logic                   mem_req,
  input  logic                   mem_gnt,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [NB-1:0]          mem_wstrb,
  output logic [INST_ID_LEN-1:0] instr_id,
  output logic                   done,
  output logic                   exc_misaligned,
  output logic                   exc_illegal
);

  state_e                 state_r, state_s;
  dec_t                   dec_s;
  logic [OFF_W-1:0]       off_s;
  logic [ADDR_W-1:0]      base_s;
  logic                   accept_s;

  size_e                  lg_size_s;
  logic [OFF_W-1:0]       lg_off_s;
  logic [XLEN-1:0]        lg_data_s;
  logic                   lg_beat2_s;
  logic [NB-1:0]          lg_wstrb_s;
  logic [XLEN-1:0]        lg_wdata_s;

  logic                   mem_req_s;
  logic [ADDR_W-1:0]      mem_addr_s;
  logic [NB-1:0]          mem_wstrb_s;
  logic [XLEN-1:0]        mem_wdata_s;
  logic                   done_s;
  logic                   exc_mis_s;
  logic                   exc_ill_s;
  logic [INST_ID_LEN-1:0] instr_id_s;

  assign off_s    = in_addr[OFF_W-1:0];
  assign base_s   = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dec_s    = decode_store(in_funct3, XLEN == 64);
  assign in_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s = in_valid && in_ready;

`ifdef STORE_MISALIGNED_SPLIT_EN
  logic                   cross_s, cross_r;
  logic [OFF_W-1:0]       off_r;
  size_e                  size_r;
  logic [XLEN-1:0]        data_r;

  assign cross_s = (int'(off_s) + int'(size_bytes(dec_s.size))) > NB;

  // Lane generator sees the new request while idle and the latched store for its second beat.
  always_comb begin
    if (state_r == ST_IDLE) begin
      lg_size_s  = dec_s.size;
      lg_off_s   = off_s;
      lg_data_s  = in_data;
      lg_beat2_s = 1'b0;
    end else begin
      lg_size_s  = size_r;
      lg_off_s   = off_r;
      lg_data_s  = data_r;
      lg_beat2_s = 1'b1;
    end
  end

  // Keep the accepted store so the second beat can be formed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cross_r <= 1'b0;
      off_r   <= '0;
      size_r  <= SZ_B;
      data_r  <= '0;
    end else if (accept_s) begin
      cross_r <= dec_s.legal && cross_s;
      off_r   <= off_s;
      size_r  <= dec_s.size;
      data_r  <= in_data;
    end else begin
      cross_r <= cross_r;
    end
  end
`else
  logic                   mis_s;

  assign mis_s      = |(off_s & OFF_W'(align_mask(dec_s.size)));
  assign lg_size_s  = dec_s.size;
  assign lg_off_s   = off_s;
  assign lg_data_s  = in_data;
  assign lg_beat2_s = 1'b0;
`endif

  store_lane_gen #(.XLEN(XLEN)) u_lane_gen (
    .size  (lg_size_s),
    .off   (lg_off_s),
    .data  (lg_data_s),
    .beat2 (lg_beat2_s),
    .wstrb (lg_wstrb_s),
    .wdata (lg_wdata_s)
  );

  // Next-state and next-output decisions; bus outputs hold unless a beat is loaded.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req;
    mem_addr_s  = mem_addr;
    mem_wstrb_s = mem_wstrb;
    mem_wdata_s = mem_wdata;
    instr_id_s  = instr_id;
    done_s      = 1'b0;
    exc_mis_s   = 1'b0;
    exc_ill_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          instr_id_s = dec_s.id;
          if (!dec_s.legal) begin
            exc_ill_s = 1'b1;
`ifndef STORE_MISALIGNED_SPLIT_EN
          end else if (mis_s) begin
            exc_mis_s = 1'b1;
`endif
          end else begin
            state_s     = ST_ISSUE;
            mem_req_s   = 1'b1;
            mem_addr_s  = base_s;
            mem_wstrb_s = lg_wstrb_s;
            mem_wdata_s = lg_wdata_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
          if (cross_r) begin
            state_s     = ST_ISSUE2;
            mem_addr_s  = mem_addr + ADDR_W'(NB);
            mem_wstrb_s = lg_wstrb_s;
            mem_wdata_s = lg_wdata_s;
          end else begin
            state_s   = ST_IDLE;
            mem_req_s = 1'b0;
            done_s    = 1'b1;
          end
`else
          state_s   = ST_IDLE;
          mem_req_s = 1'b0;
          done_s    = 1'b1;
`endif
        end else begin
          state_s = ST_ISSUE;
        end
      end
`ifdef STORE_MISALIGNED_SPLIT_EN
      ST_ISSUE2: begin
        if (mem_gnt) begin
          state_s   = ST_IDLE;
          mem_req_s = 1'b0;
          done_s    = 1'b1;
        end else begin
          state_s = ST_ISSUE2;
        end
      end
`endif
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_wstrb      <= '0;
      mem_wdata      <= '0;
      instr_id       <= NONE_ID;
      done           <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_illegal    <= 1'b0;
    end else begin
      state_r        <= state_s;
      mem_req        <= mem_req_s;
      mem_addr       <= mem_addr_s;
      mem_wstrb      <= mem_wstrb_s;
      mem_wdata      <= mem_wdata_s;
      instr_id       <= instr_id_s;
      done           <= done_s;
      exc_misaligned <= exc_mis_s;
      exc_illegal    <= exc_ill_s;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit (XLEN=32): byte-level reference model plus directed cases.
// Follows STORE_MISALIGNED_SPLIT_EN when the same macro is defined for the build.
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int NB   = XLEN / 8;
`ifdef STORE_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [2:0]             in_funct3 = 3'd0;
  logic [31:0]            in_addr = 32'd0;
  logic [XLEN-1:0]        in_data = '0;
  logic                   mem_req;
  logic                   mem_gnt = 1'b0;
  logic [31:0]            mem_addr;
  logic [XLEN-1:0]        mem_wdata;
  logic [NB-1:0]          mem_wstrb;
  logic [INST_ID_LEN-1:0] instr_id;
  logic                   done, exc_misaligned, exc_illegal;

  int vectors = 0;
  int miscompares = 0;
  int gnt_wait = 0;
  bit noise_en = 1'b0;

  // reference model state
  bit                     m_busy = 1'b0;
  bit                     beat_new = 1'b0;
  int                     nbeats = 0, cur = 0;
  logic [31:0]            b_addr [2];
  logic [NB-1:0]          b_strb [2];
  logic [XLEN-1:0]        b_data [2];
  logic                   exp_req = 1'b0, exp_done = 1'b0, exp_ill = 1'b0, exp_mis = 1'b0;
  logic [31:0]            exp_addr = 32'd0;
  logic [NB-1:0]          exp_strb = '0;
  logic [XLEN-1:0]        exp_data = '0;
  logic [INST_ID_LEN-1:0] exp_id = NONE_ID;

  store_unit #(.XLEN(XLEN), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_data(in_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .instr_id(instr_id),
    .done(done), .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_beat();
    exp_addr = b_addr[cur];
    exp_strb = b_strb[cur];
    exp_data = b_data[cur];
    beat_new = 1'b1;
  endtask

  // Model: a store is a list of bytes; bytes are grouped by the bus word they fall in.
  task automatic model_accept();
    int sz, off, idx, lane;
    logic [31:0] base;
    case (in_funct3)
      3'd0: begin sz = 1; exp_id = SB_ID; end
      3'd1: begin sz = 2; exp_id = SH_ID; end
      3'd2: begin sz = 4; exp_id = SW_ID; end
      3'd3: begin sz = (XLEN == 64) ? 8 : 0; exp_id = (XLEN == 64) ? SD_ID : NONE_ID; end
      default: begin sz = 0; exp_id = NONE_ID; end
    endcase
    if (sz == 0) begin
      exp_ill = 1'b1;
    end else begin
      off  = int'(in_addr % NB);
      base = in_addr - 32'(off);
      if ((off % sz) != 0 && !SPLIT) begin
        exp_mis = 1'b1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          b_strb[k] = '0;
          b_data[k] = '0;
          b_addr[k] = base + 32'(k * NB);
        end
        nbeats = (off + sz - 1) / NB + 1;
        for (int i = 0; i < sz; i++) begin
          idx  = (off + i) / NB;
          lane = (off + i) % NB;
          b_strb[idx][lane] = 1'b1;
          b_data[idx][lane*8 +: 8] = in_data[i*8 +: 8];
        end
        cur     = 0;
        m_busy  = 1'b1;
        exp_req = 1'b1;
        load_beat();
      end
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0; beat_new = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
        exp_ill = 1'b0; exp_mis = 1'b0; exp_id = NONE_ID;
      end else begin
        exp_done = 1'b0; exp_ill = 1'b0; exp_mis = 1'b0; beat_new = 1'b0;
        if (m_busy) begin
          if (mem_gnt) begin
            cur++;
            if (cur == nbeats) begin
              m_busy = 1'b0; exp_req = 1'b0; exp_done = 1'b1;
            end else begin
              load_beat();
            end
          end
        end else if (in_valid) begin
          model_accept();
        end
      end
    end
  end

  initial begin : compare
    logic [XLEN-1:0] bm;
    logic [XLEN-1:0] prev_wdata;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready", in_ready, !m_busy);
        chk("req", mem_req, exp_req);
        if (exp_req) begin
          for (int l = 0; l < NB; l++) bm[l*8 +: 8] = {8{exp_strb[l]}};
          chk("addr", mem_addr, exp_addr);
          chk("wstrb", mem_wstrb, exp_strb);
          chk("wdata", mem_wdata & bm, exp_data & bm);
          if (!beat_new) chk("wdata_hold", mem_wdata, prev_wdata);
        end
        chk("done", done, exp_done);
        chk("exc_illegal", exc_illegal, exp_ill);
        chk("exc_misaligned", exc_misaligned, exp_mis);
        chk("instr_id", instr_id, exp_id);
        prev_wdata = mem_wdata;
      end
    end
  end

  initial begin : gnt_drv
    int rc;
    rc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0; mem_gnt = 1'b0;
      end else if (mem_req) begin
        mem_gnt = (rc >= gnt_wait);
        rc = mem_gnt ? 0 : rc + 1;
      end else begin
        rc = 0;
        mem_gnt = noise_en ? 1'($urandom % 2) : 1'b0;
      end
    end
  end

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [XLEN-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_funct3 = f3; in_addr = a; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_id", instr_id, NONE_ID);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;

    gnt_wait = 0;
    store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw_req", mem_req, 1'b1);
    chk("sw_addr", mem_addr, 32'h0000_0100);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_done", done, 1'b1);
    chk("sw_id", instr_id, SW_ID);

    store(3'b000, 32'h0000_0103, 32'h0000_00A5);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    chk("sb_lane3", mem_wdata[31:24], 8'hA5);

    gnt_wait = 3;
    store(3'b001, 32'h0000_0102, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", mem_req, 1'b1);
      chk("sh_addr", mem_addr, 32'h0000_0100);
      chk("sh_wstrb", mem_wstrb, 4'b1100);
      chk("sh_wdata", mem_wdata[31:16], 16'h1234);
      chk("sh_no_done", done, 1'b0);
      @(negedge clk);
    end
    chk("sh_done", done, 1'b1);
    @(negedge clk);
    chk("sh_done_once", done, 1'b0);

    gnt_wait = 0;
    store(3'b011, 32'h0000_0200, 32'h1111_2222);
    chk("ill_pulse", exc_illegal, 1'b1);
    chk("ill_req", mem_req, 1'b0);
    chk("ill_id", instr_id, NONE_ID);
    @(negedge clk);
    chk("ill_end", exc_illegal, 1'b0);

    store(3'b010, 32'h0000_0101, 32'hCAFE_F00D);
`ifdef STORE_MISALIGNED_SPLIT_EN
    chk("mis_b1_addr", mem_addr, 32'h0000_0100);
    chk("mis_b1_wstrb", mem_wstrb, 4'b1110);
    @(negedge clk);
    chk("mis_b2_addr", mem_addr, 32'h0000_0104);
    chk("mis_b2_wstrb", mem_wstrb, 4'b0001);
    chk("mis_b2_done", done, 1'b0);
    @(negedge clk);
    chk("mis_done", done, 1'b1);
`else
    chk("mis_pulse", exc_misaligned, 1'b1);
    chk("mis_req", mem_req, 1'b0);
`endif

    gnt_wait = 10;
    store(3'b010, 32'h0000_0300, 32'h5555_AAAA);
    chk("abort_req_before", mem_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_req", mem_req, 1'b0);
    chk("abort_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", in_ready, 1'b1);
    chk("abort_no_done", done, 1'b0);

    noise_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      in_addr   = $urandom;
      in_data   = $urandom;
      gnt_wait  = $urandom_range(0, 3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    noise_en = 1'b0;
    gnt_wait = 0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
